// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage with redirect squash; optional IFU_MISALIGN_CHK_EN traps misaligned redirect targets
module ifu_fetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic drop, drop_n, fault, fault_n, cap;
  assign req_valid   = state == REQ;
  assign req_addr    = pc;
  assign inst_valid  = state == HOLD && !fault;
  assign fetch_fault = fault;
  always_comb begin
    state_n = state;
    drop_n  = drop;
    cap     = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      // a redirect coinciding with acceptance means the issued address is already stale
      REQ: if (req_ready) begin
        state_n = WAIT;
        drop_n  = redirect_valid;
      end
      WAIT: if (rsp_valid) begin
        drop_n  = 1'b0;
        cap     = !(drop || redirect_valid);
        state_n = cap ? HOLD : REQ;
      end else if (redirect_valid) drop_n = 1'b1;
      HOLD: state_n = (redirect_valid || inst_ready) ? REQ : HOLD;
      default: state_n = IDLE;
    endcase
    pc_n = redirect_valid ? redirect_pc : (state == HOLD && inst_ready) ? pc + XLEN'(4) : pc;
`ifdef IFU_MISALIGN_CHK_EN
    fault_n = fault || (redirect_valid && redirect_pc[1:0] != 2'b00);
    if (fault_n) state_n = IDLE;
`else
    fault_n = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      fault   <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      fault <= fault_n;
      if (cap) begin
        inst    <= rsp_data;
        inst_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenario bench for ifu_fetch
module tb_ifu_fetch;
  logic clk = 0, reset = 1, req_ready = 0, rsp_valid = 0, inst_ready = 0, redirect_valid = 0;
  logic [31:0] rsp_data = 0, redirect_pc = 0;
  logic req_valid, inst_valid, fetch_fault;
  logic [31:0] req_addr, inst, inst_pc;
  int checks = 0, errors = 0;

  ifu_fetch dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h13572468;
  endfunction

  task automatic fetch_one(input logic [31:0] a, input int lat);
    int n = 0;
    while (req_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (req_valid !== 1'b1 || req_addr !== a) begin
      errors++;
      $display("FAIL fetch_req valid=%b addr=%h expected addr=%h", req_valid, req_addr, a);
    end
    req_ready = 1; @(negedge clk); req_ready = 0;
    repeat (lat) @(negedge clk);
    rsp_valid = 1; rsp_data = word(a); @(negedge clk); rsp_valid = 0;
  endtask

  task automatic consume();
    inst_ready = 1; @(negedge clk); inst_ready = 0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1; redirect_pc = t; @(negedge clk); redirect_valid = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({req_valid, inst_valid, fetch_fault} !== 3'b000 || inst !== 0 || inst_pc !== 0 || req_addr !== 32'h80000000) begin
      errors++;
      $display("FAIL reset_state rv=%b iv=%b ff=%b inst=%h pc=%h addr=%h", req_valid, inst_valid, fetch_fault, inst, inst_pc, req_addr);
    end
    reset = 0; #1;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_idle req_valid=%b expected 0", req_valid); end
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h80000000) begin
      errors++; $display("FAIL reset_first_req valid=%b addr=%h expected 1/80000000", req_valid, req_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h80000000 + 32'(4 * i);
      fetch_one(a, 0);
      checks++;
      if (inst_valid !== 1'b1 || inst !== word(a) || inst_pc !== a) begin
        errors++; $display("FAIL seq_inst valid=%b inst=%h pc=%h expected %h/%h", inst_valid, inst, inst_pc, word(a), a);
      end
      consume();
    end
  endtask

  task automatic test_hold_stall();
    fetch_one(32'h8000000C, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || req_valid !== 1'b0 || inst !== word(32'h8000000C) || inst_pc !== 32'h8000000C) begin
        errors++; $display("FAIL hold_stable cyc=%0d iv=%b rv=%b inst=%h pc=%h", i, inst_valid, req_valid, inst, inst_pc);
      end
      @(negedge clk);
    end
    consume();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h80000010 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL hold_advance rv=%b addr=%h iv=%b expected 1/80000010/0", req_valid, req_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_hold();
    fetch_one(32'h80000010, 0);
    checks++;
    if (inst_pc !== 32'h80000010 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL rh_inst pc=%h iv=%b expected 80000010/1", inst_pc, inst_valid);
    end
    inst_ready = 1; redirect(32'h80000040); inst_ready = 0;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000040) begin
      errors++; $display("FAIL rh_target iv=%b rv=%b addr=%h expected 0/1/80000040", inst_valid, req_valid, req_addr);
    end
    fetch_one(32'h80000040, 1);
    checks++;
    if (inst !== word(32'h80000040) || inst_pc !== 32'h80000040) begin
      errors++; $display("FAIL rh_delivered inst=%h pc=%h expected %h/80000040", inst, inst_pc, word(32'h80000040));
    end
    consume();
  endtask

  task automatic test_redirect_wait();
    req_ready = 1; @(negedge clk); req_ready = 0;
    redirect(32'h80000100);
    repeat (2) @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL rw_waiting rv=%b iv=%b expected 0/0", req_valid, inst_valid);
    end
    rsp_valid = 1; rsp_data = 32'hDEADBEEF; @(negedge clk); rsp_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000100) begin
      errors++; $display("FAIL rw_discard iv=%b rv=%b addr=%h expected 0/1/80000100", inst_valid, req_valid, req_addr);
    end
    fetch_one(32'h80000100, 0);
    checks++;
    if (inst_valid !== 1'b1 || inst !== word(32'h80000100) || inst_pc !== 32'h80000100) begin
      errors++; $display("FAIL rw_delivered iv=%b inst=%h pc=%h", inst_valid, inst, inst_pc);
    end
    consume();
    req_ready = 1; redirect(32'h80000200); req_ready = 0;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL rr_wait rv=%b expected 0", req_valid); end
    rsp_valid = 1; rsp_data = 32'hCAFEBABE; @(negedge clk); rsp_valid = 0;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000200) begin
      errors++; $display("FAIL rr_discard iv=%b rv=%b addr=%h expected 0/1/80000200", inst_valid, req_valid, req_addr);
    end
    redirect(32'h80000300);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h80000300) begin
      errors++; $display("FAIL req_follow rv=%b addr=%h expected 1/80000300", req_valid, req_addr);
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFFFFFC);
    fetch_one(32'hFFFFFFFC, 0);
    checks++;
    if (inst_pc !== 32'hFFFFFFFC || inst !== word(32'hFFFFFFFC)) begin
      errors++; $display("FAIL wrap_inst pc=%h inst=%h", inst_pc, inst);
    end
    consume();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h00000000) begin
      errors++; $display("FAIL wrap_pc rv=%b addr=%h expected 1/00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_reset_mid();
    redirect(32'h80000020);
    fetch_one(32'h80000020, 0);
    consume();
    req_ready = 1; @(negedge clk); req_ready = 0;
    #2 reset = 1; #1;
    checks++;
    if ({req_valid, inst_valid} !== 2'b00 || inst !== 0 || inst_pc !== 0 || req_addr !== 32'h80000000) begin
      errors++; $display("FAIL async_clear rv=%b iv=%b inst=%h pc=%h addr=%h", req_valid, inst_valid, inst, inst_pc, req_addr);
    end
    @(negedge clk); reset = 0; #1;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL mid_idle rv=%b expected 0", req_valid); end
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h80000000) begin
      errors++; $display("FAIL mid_restart rv=%b addr=%h expected 1/80000000", req_valid, req_addr);
    end
    fetch_one(32'h80000000, 0);
    checks++;
    if (inst_pc !== 32'h80000000 || inst !== word(32'h80000000)) begin
      errors++; $display("FAIL mid_fetch pc=%h inst=%h", inst_pc, inst);
    end
    consume();
  endtask

  task automatic test_misalign();
    redirect(32'h80000102);
`ifdef IFU_MISALIGN_CHK_EN
    checks++;
    if (fetch_fault !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL mis_fault ff=%b rv=%b iv=%b expected 1/0/0", fetch_fault, req_valid, inst_valid);
    end
    req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b0 || fetch_fault !== 1'b1) begin
        errors++; $display("FAIL mis_stuck cyc=%0d rv=%b ff=%b expected 0/1", i, req_valid, fetch_fault);
      end
    end
    req_ready = 0;
`else
    checks++;
    if (fetch_fault !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h80000102) begin
      errors++; $display("FAIL mis_nochk ff=%b rv=%b addr=%h expected 0/1/80000102", fetch_fault, req_valid, req_addr);
    end
    fetch_one(32'h80000102, 0);
    checks++;
    if (inst_pc !== 32'h80000102 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL mis_fetch pc=%h iv=%b expected 80000102/1", inst_pc, inst_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_wrap();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage, directly upstream of the single-cycle RV32 execute core.
- Owns the architectural PC and issues one instruction-memory request at a time over a simple valid/ready bus.
- Buffers the returned word and presents {inst, inst_pc} to the core with a valid/ready handshake.
- Accepts PC redirects (the core's dnpc on taken jal/jalr) and squashes any in-flight or buffered wrong-path fetch.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address (= current PC)
- rsp_valid  in  1  memory response valid, one cycle pulse, never before request accepted
- rsp_data  in  32  fetched instruction word
- inst_valid  out  1  instruction available to core
- inst_ready  in  1  core consumes instruction
- inst  out  32  buffered instruction
- inst_pc  out  XLEN  PC of buffered instruction
- redirect_valid  in  1  PC redirect request
- redirect_pc  in  XLEN  redirect target
- fetch_fault  out  1  sticky misaligned-target flag (IFU_MISALIGN_CHK_EN only, else tied 0)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset state (asynchronous):
  - pc = RESET_PC; state = IDLE; drop = 0.
  - req_valid = 0; inst_valid = 0; inst = 0; inst_pc = 0; fetch_fault = 0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: exactly one cycle after reset release, then go to REQ.
- REQ:
  - req_valid = 1, req_addr = pc (combinational from pc).
  - On req_ready, go to WAIT.
- WAIT:
  - req_valid = 0.
  - On rsp_valid with drop = 0: capture inst <= rsp_data, inst_pc <= pc, go to HOLD.
  - On rsp_valid with drop = 1: discard the data, clear drop, go to REQ.
- HOLD:
  - inst_valid = 1; inst and inst_pc held stable until consumed.
  - On inst_ready: pc <= pc + 4 (mod 2^XLEN; wrap from 0xFFFFFFFC to 0), go to REQ.
- Latency: best case 1 cycle in REQ plus 1 cycle in WAIT (zero-wait memory), so inst_valid asserts 2 cycles after entering REQ. Sustained throughput is 1 instruction per 3 cycles. Only one request is outstanding at a time.
- Redirect (redirect_valid = 1) has priority over sequential update; pc <= redirect_pc in every state.
  - REQ without req_ready: req_addr follows the new pc next cycle. The bus tolerates an address change while valid.
  - REQ with req_ready in the same cycle: the old request is already issued, so set drop = 1 and go to WAIT.
  - WAIT: set drop = 1. If rsp_valid arrives in the same cycle, discard it and go straight to REQ with drop = 0.
  - HOLD: inst_valid deasserts next cycle; go to REQ. If inst_ready is also high, the instruction counts as consumed, but pc still takes redirect_pc, not pc + 4.
  - IDLE: pc updated; go to REQ as normal.
- Reset asserted mid-transaction: all state clears immediately. The response to the abandoned request must be ignored. The bench guarantees no stray rsp_valid after reset; the design does not need to track it.
- rsp_valid outside WAIT is ignored.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 sets fetch_fault = 1, which stays set until reset.
  - pc still loads redirect_pc.
  - The FSM goes to, or stays in, IDLE and issues no further requests until reset.
  - inst_valid is forced to 0.
- Undefined: no check is made, fetch_fault is tied to 0, and a misaligned target is fetched as is.

Test Plan:
- Reset, then memory always ready with a 1-cycle response -> first req_addr = 0x80000000; inst_valid with inst_pc 0x80000000 then 0x80000004, 0x80000008, each word matching memory.
- inst_ready held low 5 cycles in HOLD -> inst and inst_pc stable for 5 cycles; no new req_valid; pc advances by 4 only after the handshake.
- Redirect to 0x80000100 while in WAIT, response arrives 3 cycles later -> that response is discarded; next req_addr = 0x80000100; delivered inst_pc = 0x80000100.
- Redirect and inst_ready in the same HOLD cycle (inst_pc 0x80000010, target 0x80000040) -> next req_addr = 0x80000040, not 0x80000014.
- Reset asserted during WAIT -> outputs clear asynchronously; after release, exactly one IDLE cycle, then req_addr = 0x80000000.
- With IFU_MISALIGN_CHK_EN, redirect to 0x80000102 -> fetch_fault = 1 next cycle; req_valid stays 0 until reset. Without the macro -> req_addr = 0x80000102.
